// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter (ALU / load) for the register
//               file write port, plus a per-register pending-write scoreboard.
//               Optional macro WB_FORWARD_EN adds a same-cycle bypass output.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
`ifdef WB_FORWARD_EN
    output logic                  fwd_valid,
    output logic [ADDR_W-1:0]     fwd_addr,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  sb_err
);

    localparam int        c_NREG    = 2**ADDR_W;
    localparam logic      c_PRIO_A  = 1'b0;
    localparam logic      c_PRIO_B  = 1'b1;
    localparam logic [1:0] c_CNT_MAX = 2'd3;

    logic                r_prio;
    logic                w_a_xfer;
    logic                w_b_xfer;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_data;
    logic [c_NREG-1:0]   w_err_set;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_sb_err;

    // With both requesters valid, exactly one of the readies is high, so at
    // most one transfer can occur per cycle.
    assign a_ready    = !b_valid || (r_prio == c_PRIO_A);
    assign b_ready    = !a_valid || (r_prio == c_PRIO_B);
    assign w_a_xfer   = a_valid && a_ready;
    assign w_b_xfer   = b_valid && b_ready;
    assign w_xfer     = w_a_xfer || w_b_xfer;
    assign w_gnt_addr = w_a_xfer ? a_addr : b_addr;
    assign w_gnt_data = w_a_xfer ? a_data : b_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio    <= c_PRIO_A;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_sb_err  <= 1'b0;
        end else begin
            r_wr_en  <= w_xfer;
            r_sb_err <= r_sb_err || (|w_err_set);
            if (w_xfer) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
            end
            if (w_a_xfer) begin
                r_prio <= c_PRIO_B;
            end else if (w_b_xfer) begin
                r_prio <= c_PRIO_A;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_NREG; gi++) begin : g_cnt
            logic [1:0] r_cnt;
            logic       w_inc;
            logic       w_dec;

            assign w_inc = issue_en && (issue_addr == ADDR_W'(gi));
            assign w_dec = w_xfer && (w_gnt_addr == ADDR_W'(gi));

            // Saturating counter; simultaneous inc/dec cancel out.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 2'd0;
                end else if (w_inc && !w_dec && (r_cnt != c_CNT_MAX)) begin
                    r_cnt <= r_cnt + 2'd1;
                end else if (w_dec && !w_inc && (r_cnt != 2'd0)) begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end

            assign w_err_set[gi] = (w_inc && !w_dec && (r_cnt == c_CNT_MAX)) ||
                                   (w_dec && !w_inc && (r_cnt == 2'd0));
            assign busy[gi]      = (r_cnt != 2'd0);
        end
    endgenerate

`ifdef WB_FORWARD_EN
    assign fwd_valid = w_xfer;
    assign fwd_addr  = w_gnt_addr;
    assign fwd_data  = w_gnt_data;
`endif

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign sb_err  = r_sb_err;

endmodule
`default_nettype wire
